pcpi_op_counter: RTL and testbench
==================================

# pcpi_op_counter

Per-node statistics block that counts accepted PCPI co-processor operations by class and hands a frozen snapshot to `self_awareness` when the task finishes. It sits between the PicoRV32 PCPI handshake inside `picorv32_if_wrapper` and `self_awareness`. It produces the eight `*_count` values consumed when `PCPI_COUNT` is defined. It runs on the ungated node `clk`, so counts survive clock gating of the core.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of each counter and snapshot register.

Ports:
- `clk`  in  1  node clock (ungated).
- `res_n`  in  1  reset; asynchronous, active-low.
- `core_active`  in  1  core enabled (`w_activate`); counting only when high.
- `pcpi_valid`  in  1  PCPI request valid from the core.
- `pcpi_insn`  in  32  PCPI instruction word.
- `pcpi_ready`  in  1  co-processor completion; an op is accepted when `pcpi_valid && pcpi_ready`.
- `snap`  in  1  one-cycle pulse (`w_fin`) requesting a snapshot.
- `snap_ack`  in  1  `self_awareness` has consumed the snapshot.
- `clr`  in  1  synchronous clear of live counters.
- `intmul_count`, `intdiv_count`, `fpadd_count`, `fpsub_count`, `intmulx_count`, `fpmul_count`, `fpdiv_count`, `fpmulx_count`  out  `CNT_WIDTH` each  snapshot values.
- `snap_valid`  out  1  snapshot outputs are stable and valid.
- `ovf`  out  8  per-class overflow flags of the snapshot; bit order matches the count list above.

## Operation
- Classification of an accepted op:
  - Opcode 0110011 with funct7 0000001: funct3 0–3 → intmul, funct3 4–7 → intdiv.
  - Opcode 0001011 (custom-0), by funct3: 000 fpadd, 001 fpsub, 010 fpmul, 011 fpdiv, 100 intmulx, 101 fpmulx.
  - Any other encoding is not counted.
- Each accepted op increments exactly one live counter by 1. A multi-cycle op is counted once, on the cycle `pcpi_ready` is high.
- FSM states:
  - IDLE: live counters hold, no counting. `core_active`=1 → COUNT.
  - COUNT: count accepted ops. `snap`=1 → copy live counters (plus the same-cycle op) into snapshot registers, zero live counters, set `snap_valid` → HOLD. `core_active`=0 with no `snap` → IDLE.
  - HOLD: snapshot registers frozen, `snap_valid`=1, live counters keep counting if `core_active`. `snap_ack`=1 → clear `snap_valid` → COUNT if `core_active`, else IDLE.
- `snap` received in HOLD is ignored; the first snapshot is preserved.
- `snap` received in IDLE takes a snapshot exactly as in COUNT.
- `clr` zeroes the live counters and live overflow flags in any state. It has no effect on the snapshot. If `clr` and an accepted op occur in the same cycle, the counter ends at 0.
- If `clr` and `snap` occur in the same cycle, the snapshot captures the pre-clear value and the live counters end at 0.

## Timing
- Reset: all counters, snapshot registers, `ovf` and `snap_valid` are 0; the FSM is in IDLE. Reset mid-op discards everything.
- Live counter update: 1 cycle after the accepted handshake.
- Snapshot: outputs and `snap_valid` are valid on the cycle after `snap`.
- `snap_valid` falls on the cycle after `snap_ack`.
- Snapshot outputs change only on the snapshot-capture edge and on reset.

## Configuration
- `PCPI_COUNT_SAT_EN` defined: counters saturate at 2^`CNT_WIDTH`−1. The `ovf` bit for a class sets when a count hits the maximum.
- Not defined: counters wrap modulo 2^`CNT_WIDTH`. The `ovf` bit for a class sets sticky on the wrap from all-ones to 0.
- In both cases `ovf` is cleared by `clr` (live flag) and reset only.

## Structure
- `pcpi_count_pkg` holds:
  - `pcpi_op_e` enum (INTMUL…FPMULX, NONE).
  - `NUM_PCPI_OPS`=8.
  - Opcode, funct7 and funct3 constants.
  - FSM state typedef.
- Sub-module `pcpi_op_decode`: combinational, takes `pcpi_insn` and returns `pcpi_op_e`. It is instantiated once.

## Test plan
- Reset, then 3 MUL, 2 DIVU and 1 custom-0 funct3=000, then `snap` → intmul=3, intdiv=2, fpadd=1, others 0, `snap_valid`=1 next cycle.
- Accepted op coincident with `snap` → the op is included in the snapshot and live counters read 0 afterwards.
- With `CNT_WIDTH`=4, 17 fpmul ops: SAT_EN gives fpmul=15 with ovf[5]=1; without it, fpmul=1 with ovf[5]=1.
- `pcpi_valid` held 5 cycles with `pcpi_ready` only on the last → count +1. Ops while `core_active`=0 → no change.
- Second `snap` in HOLD → snapshot unchanged. Then `snap_ack` → `snap_valid`=0 next cycle.
- `res_n` asserted asynchronously during HOLD → all outputs 0 in the same cycle, FSM in IDLE.

Source files
------------

// File: rtl/pcpi_op_counter_pkg.sv
// ============================================================================
// Package     : pcpi_count_pkg
// Description : Op classes, encoding constants and FSM state for the PCPI
//               op counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcpi_count_pkg;

  localparam int NUM_PCPI_OPS = 8;
  localparam int INSN_WIDTH   = 32;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_MULDIV   = 7'b0000001;

  localparam logic [2:0] F3_FPADD    = 3'b000;
  localparam logic [2:0] F3_FPSUB    = 3'b001;
  localparam logic [2:0] F3_FPMUL    = 3'b010;
  localparam logic [2:0] F3_FPDIV    = 3'b011;
  localparam logic [2:0] F3_INTMULX  = 3'b100;
  localparam logic [2:0] F3_FPMULX   = 3'b101;

  // Enum order is the counter index and the ovf bit order.
  typedef enum logic [3:0] {
    OP_INTMUL  = 4'd0,
    OP_INTDIV  = 4'd1,
    OP_FPADD   = 4'd2,
    OP_FPSUB   = 4'd3,
    OP_INTMULX = 4'd4,
    OP_FPMUL   = 4'd5,
    OP_FPDIV   = 4'd6,
    OP_FPMULX  = 4'd7,
    OP_NONE    = 4'd8
  } pcpi_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } cnt_state_e;

endpackage

`default_nettype wire

// File: rtl/pcpi_op_counter_if.sv
// ============================================================================
// Interface   : pcpi_op_counter_if
// Description : PCPI handshake as seen by the op counter (monitor only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pcpi_op_counter_if;
  import pcpi_count_pkg::*;

  logic                  valid;
  logic [INSN_WIDTH-1:0] insn;
  logic                  ready;

  modport master (output valid, output insn, output ready);
  modport slave  (input  valid, input  insn, input  ready);
endinterface

`default_nettype wire

// File: rtl/pcpi_op_counter_decode.sv
// ============================================================================
// Module      : pcpi_op_decode
// Description : Classifies a PCPI instruction word into a counted op class.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcpi_op_decode
  import pcpi_count_pkg::*;
(
  input  logic [INSN_WIDTH-1:0] insn,
  output pcpi_op_e              op
);

  logic       w_unused;
  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;

  assign w_opcode = insn[6:0];
  assign w_funct7 = insn[31:25];
  assign w_funct3 = insn[14:12];
  assign w_unused = ^{insn[24:15], insn[11:7]};

  always_comb begin
    op = OP_NONE;
    if (w_opcode == OPC_OP && w_funct7 == F7_MULDIV) begin
      op = w_funct3[2] ? OP_INTDIV : OP_INTMUL;
    end else if (w_opcode == OPC_CUSTOM0) begin
      case (w_funct3)
        F3_FPADD:   op = OP_FPADD;
        F3_FPSUB:   op = OP_FPSUB;
        F3_FPMUL:   op = OP_FPMUL;
        F3_FPDIV:   op = OP_FPDIV;
        F3_INTMULX: op = OP_INTMULX;
        F3_FPMULX:  op = OP_FPMULX;
        default:    op = OP_NONE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcpi_op_counter.sv
// ============================================================================
// Module      : pcpi_op_counter
// Description : Per-class PCPI op counters with a frozen snapshot handed off
//               on task finish. PCPI_COUNT_SAT_EN selects saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcpi_op_counter
  import pcpi_count_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    core_active,
  pcpi_op_counter_if.slave        pcpi,
  input  logic                    snap,
  input  logic                    snap_ack,
  input  logic                    clr,
  output logic [CNT_WIDTH-1:0]    intmul_count,
  output logic [CNT_WIDTH-1:0]    intdiv_count,
  output logic [CNT_WIDTH-1:0]    fpadd_count,
  output logic [CNT_WIDTH-1:0]    fpsub_count,
  output logic [CNT_WIDTH-1:0]    intmulx_count,
  output logic [CNT_WIDTH-1:0]    fpmul_count,
  output logic [CNT_WIDTH-1:0]    fpdiv_count,
  output logic [CNT_WIDTH-1:0]    fpmulx_count,
  output logic                    snap_valid,
  output logic [NUM_PCPI_OPS-1:0] ovf
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_one     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  cnt_state_e                             r_state;
  logic [NUM_PCPI_OPS-1:0][CNT_WIDTH-1:0] r_live;
  logic [NUM_PCPI_OPS-1:0][CNT_WIDTH-1:0] r_snap;
  logic [NUM_PCPI_OPS-1:0][CNT_WIDTH-1:0] w_next_cnt;
  logic [NUM_PCPI_OPS-1:0]                r_live_ovf;
  logic [NUM_PCPI_OPS-1:0]                r_snap_ovf;
  logic [NUM_PCPI_OPS-1:0]                w_next_ovf;
  logic [NUM_PCPI_OPS-1:0]                w_inc;
  logic                                   r_snap_valid;
  pcpi_op_e                               w_op;
  logic [3:0]                             w_op_idx;
  logic                                   w_count_en;
  logic                                   w_capture;

  pcpi_op_decode u_decode (
    .insn (pcpi.insn),
    .op   (w_op)
  );

  assign w_op_idx   = w_op;
  assign w_count_en = (r_state != ST_IDLE) && core_active && pcpi.valid && pcpi.ready;
  // A snap arriving while a snapshot is still held is dropped.
  assign w_capture  = snap && (r_state != ST_HOLD);

  for (genvar i = 0; i < NUM_PCPI_OPS; i++) begin : g_cnt
    assign w_inc[i] = w_count_en && (w_op_idx == 4'(i));
`ifdef PCPI_COUNT_SAT_EN
    assign w_next_cnt[i] = (w_inc[i] && r_live[i] != c_cnt_max) ? r_live[i] + c_one : r_live[i];
    assign w_next_ovf[i] = r_live_ovf[i] | (w_inc[i] && r_live[i] == c_cnt_max - c_one);
`else
    assign w_next_cnt[i] = w_inc[i] ? r_live[i] + c_one : r_live[i];
    assign w_next_ovf[i] = r_live_ovf[i] | (w_inc[i] && r_live[i] == c_cnt_max);
`endif
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state      <= ST_IDLE;
      r_live       <= '0;
      r_live_ovf   <= '0;
      r_snap       <= '0;
      r_snap_ovf   <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state      <= ST_HOLD;
            r_snap_valid <= 1'b1;
          end else if (core_active) begin
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (w_capture) begin
            r_state      <= ST_HOLD;
            r_snap_valid <= 1'b1;
          end else if (!core_active) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (snap_ack) begin
            r_snap_valid <= 1'b0;
            r_state      <= core_active ? ST_COUNT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Snapshot takes the pre-clear value, including any same-cycle op.
      if (w_capture) begin
        r_snap     <= w_next_cnt;
        r_snap_ovf <= w_next_ovf;
      end

      if (clr) begin
        r_live     <= '0;
        r_live_ovf <= '0;
      end else begin
        r_live     <= w_capture ? '0 : w_next_cnt;
        r_live_ovf <= w_next_ovf;
      end
    end
  end

  assign intmul_count  = r_snap[OP_INTMUL];
  assign intdiv_count  = r_snap[OP_INTDIV];
  assign fpadd_count   = r_snap[OP_FPADD];
  assign fpsub_count   = r_snap[OP_FPSUB];
  assign intmulx_count = r_snap[OP_INTMULX];
  assign fpmul_count   = r_snap[OP_FPMUL];
  assign fpdiv_count   = r_snap[OP_FPDIV];
  assign fpmulx_count  = r_snap[OP_FPMULX];
  assign snap_valid    = r_snap_valid;
  assign ovf           = r_snap_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pcpi_op_counter.sv
// ============================================================================
// Module      : tb_pcpi_op_counter
// Description : Directed bench for pcpi_op_counter; a 32-bit and a 4-bit
//               instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcpi_op_counter;
  import pcpi_count_pkg::*;

  logic clk = 1'b0;
  logic res_n, core_active, snap, snap_ack, clr;
  int   tests = 0;
  int   fails = 0;

  pcpi_op_counter_if bus ();

  logic [31:0] a_im, a_id, a_fa, a_fs, a_imx, a_fm, a_fd, a_fmx;
  logic [3:0]  b_im, b_id, b_fa, b_fs, b_imx, b_fm, b_fd, b_fmx;
  logic        a_valid, b_valid;
  logic [7:0]  a_ovf, b_ovf;
  logic [255:0] a_vec;
  logic [31:0]  b_vec;

  assign a_vec = {a_im, a_id, a_fa, a_fs, a_imx, a_fm, a_fd, a_fmx};
  assign b_vec = {b_im, b_id, b_fa, b_fs, b_imx, b_fm, b_fd, b_fmx};

  always #5 clk = ~clk;

  pcpi_op_counter #(.CNT_WIDTH(32)) dut_a (
    .clk(clk), .res_n(res_n), .core_active(core_active), .pcpi(bus),
    .snap(snap), .snap_ack(snap_ack), .clr(clr),
    .intmul_count(a_im), .intdiv_count(a_id), .fpadd_count(a_fa), .fpsub_count(a_fs),
    .intmulx_count(a_imx), .fpmul_count(a_fm), .fpdiv_count(a_fd), .fpmulx_count(a_fmx),
    .snap_valid(a_valid), .ovf(a_ovf)
  );

  pcpi_op_counter #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .res_n(res_n), .core_active(core_active), .pcpi(bus),
    .snap(snap), .snap_ack(snap_ack), .clr(clr),
    .intmul_count(b_im), .intdiv_count(b_id), .fpadd_count(b_fa), .fpsub_count(b_fs),
    .intmulx_count(b_imx), .fpmul_count(b_fm), .fpdiv_count(b_fd), .fpmulx_count(b_fmx),
    .snap_valid(b_valid), .ovf(b_ovf)
  );

  function automatic logic [255:0] ea(int im, int id, int fa, int fs, int imx, int fm, int fd, int fmx);
    return {32'(im), 32'(id), 32'(fa), 32'(fs), 32'(imx), 32'(fm), 32'(fd), 32'(fmx)};
  endfunction

  function automatic logic [31:0] eb(int im, int id, int fa, int fs, int imx, int fm, int fd, int fmx);
    return {4'(im), 4'(id), 4'(fa), 4'(fs), 4'(imx), 4'(fm), 4'(fd), 4'(fmx)};
  endfunction

  function automatic logic [31:0] muldiv(logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] cust(logic [2:0] f3);
    return {7'b0000000, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic [31:0] insn);
    bus.valid = 1'b1; bus.ready = 1'b1; bus.insn = insn;
    cyc();
    bus.valid = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1; cyc(); snap = 1'b0;
  endtask

  task automatic do_ack();
    snap_ack = 1'b1; cyc(); snap_ack = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    tests++;
    if (a_vec !== '0 || a_ovf !== 8'h00 || a_valid !== 1'b0) begin
      fails++; $display("FAIL reset_a: vec=%h ovf=%h valid=%b, want all 0", a_vec, a_ovf, a_valid);
    end
    tests++;
    if (b_vec !== '0 || b_ovf !== 8'h00 || b_valid !== 1'b0) begin
      fails++; $display("FAIL reset_b: vec=%h ovf=%h valid=%b, want all 0", b_vec, b_ovf, b_valid);
    end
    res_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    core_active = 1'b1;
    cyc();
    op(muldiv(3'b000)); op(muldiv(3'b001)); op(muldiv(3'b011));
    op(muldiv(3'b101)); op(muldiv(3'b101));
    op(cust(3'b000));
    op({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011});  // plain ADD
    op(cust(3'b110));
    do_snap();
    tests++;
    if (a_vec !== ea(3,2,1,0,0,0,0,0) || a_valid !== 1'b1) begin
      fails++; $display("FAIL basic_a: vec=%h valid=%b, want %h valid=1", a_vec, a_valid, ea(3,2,1,0,0,0,0,0));
    end
    tests++;
    if (b_vec !== eb(3,2,1,0,0,0,0,0) || b_valid !== 1'b1) begin
      fails++; $display("FAIL basic_b: vec=%h valid=%b, want %h valid=1", b_vec, b_valid, eb(3,2,1,0,0,0,0,0));
    end
    do_ack();
    tests++;
    if (a_valid !== 1'b0) begin
      fails++; $display("FAIL basic_ack: valid=%b, want 0", a_valid);
    end
  endtask

  task automatic test_snap_coincident();
    op(cust(3'b001)); op(cust(3'b001));
    snap = 1'b1;
    op(cust(3'b100));
    snap = 1'b0;
    tests++;
    if (a_vec !== ea(0,0,0,2,1,0,0,0)) begin
      fails++; $display("FAIL coincident_snap: vec=%h, want %h", a_vec, ea(0,0,0,2,1,0,0,0));
    end
    do_ack();
    do_snap();
    tests++;
    if (a_vec !== '0 || b_vec !== '0) begin
      fails++; $display("FAIL coincident_live_zero: a=%h b=%h, want 0", a_vec, b_vec);
    end
    do_ack();
  endtask

  task automatic test_handshake();
    bus.valid = 1'b1; bus.insn = cust(3'b011); bus.ready = 1'b0;
    repeat (4) cyc();
    bus.ready = 1'b1;
    cyc();
    bus.valid = 1'b0; bus.ready = 1'b0;
    core_active = 1'b0;
    op(cust(3'b000)); op(cust(3'b000)); op(muldiv(3'b000));
    do_snap();  // taken from IDLE
    tests++;
    if (a_vec !== ea(0,0,0,0,0,0,1,0) || a_valid !== 1'b1) begin
      fails++; $display("FAIL handshake: vec=%h valid=%b, want %h valid=1", a_vec, a_valid, ea(0,0,0,0,0,0,1,0));
    end
    do_ack();
  endtask

  task automatic test_hold_snap();
    core_active = 1'b1;
    cyc();
    op(cust(3'b101));
    do_snap();
    op(muldiv(3'b010));
    do_snap();
    tests++;
    if (a_vec !== ea(0,0,0,0,0,0,0,1) || a_valid !== 1'b1) begin
      fails++; $display("FAIL hold_snap_ignored: vec=%h valid=%b, want %h valid=1", a_vec, a_valid, ea(0,0,0,0,0,0,0,1));
    end
    do_ack();
    tests++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      fails++; $display("FAIL hold_ack: a_valid=%b b_valid=%b, want 0", a_valid, b_valid);
    end
    do_snap();
    tests++;
    if (a_vec !== ea(1,0,0,0,0,0,0,0)) begin
      fails++; $display("FAIL hold_live_count: vec=%h, want %h", a_vec, ea(1,0,0,0,0,0,0,0));
    end
    do_ack();
  endtask

  task automatic test_clr();
    op(muldiv(3'b100)); op(muldiv(3'b100));
    clr = 1'b1;
    op(muldiv(3'b100));
    clr = 1'b0;
    op(muldiv(3'b110));
    do_snap();
    tests++;
    if (a_vec !== ea(0,1,0,0,0,0,0,0)) begin
      fails++; $display("FAIL clr_with_op: vec=%h, want %h", a_vec, ea(0,1,0,0,0,0,0,0));
    end
    do_ack();
    op(cust(3'b000)); op(cust(3'b000));
    clr = 1'b1; snap = 1'b1;
    cyc();
    clr = 1'b0; snap = 1'b0;
    tests++;
    if (a_vec !== ea(0,0,2,0,0,0,0,0)) begin
      fails++; $display("FAIL clr_snap_pre: vec=%h, want %h", a_vec, ea(0,0,2,0,0,0,0,0));
    end
    do_ack();
    do_snap();
    tests++;
    if (a_vec !== '0) begin
      fails++; $display("FAIL clr_snap_live: vec=%h, want 0", a_vec);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    clr = 1'b1; cyc(); clr = 1'b0;
    repeat (17) op(cust(3'b010));
    do_snap();
    tests++;
    if (a_vec !== ea(0,0,0,0,0,17,0,0) || a_ovf !== 8'h00) begin
      fails++; $display("FAIL ovf_a: vec=%h ovf=%h, want %h ovf=00", a_vec, a_ovf, ea(0,0,0,0,0,17,0,0));
    end
`ifdef PCPI_COUNT_SAT_EN
    tests++;
    if (b_fm !== 4'd15 || b_ovf !== 8'h20) begin
      fails++; $display("FAIL ovf_b_sat: fpmul=%0d ovf=%h, want 15 ovf=20", b_fm, b_ovf);
    end
`else
    tests++;
    if (b_fm !== 4'd1 || b_ovf !== 8'h20) begin
      fails++; $display("FAIL ovf_b_wrap: fpmul=%0d ovf=%h, want 1 ovf=20", b_fm, b_ovf);
    end
`endif
    do_ack();
    op(cust(3'b010));
    do_snap();
    tests++;
    if (b_ovf !== 8'h20) begin
      fails++; $display("FAIL ovf_sticky: ovf=%h, want 20", b_ovf);
    end
    do_ack();
    clr = 1'b1; cyc(); clr = 1'b0;
    do_snap();
    tests++;
    if (b_ovf !== 8'h00 || b_vec !== '0) begin
      fails++; $display("FAIL ovf_clr: ovf=%h vec=%h, want 0", b_ovf, b_vec);
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    op(muldiv(3'b000));
    do_snap();
    #2;
    res_n = 1'b0;
    #1;
    tests++;
    if (a_vec !== '0 || a_ovf !== 8'h00 || a_valid !== 1'b0 || b_vec !== '0 || b_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset: a=%h ovf=%h va=%b b=%h vb=%b, want 0", a_vec, a_ovf, a_valid, b_vec, b_valid);
    end
    tests++;
    if (dut_a.r_state !== ST_IDLE) begin
      fails++; $display("FAIL async_reset_state: state=%0d, want %0d", dut_a.r_state, ST_IDLE);
    end
    res_n = 1'b1;
    cyc();
  endtask

  initial begin
    res_n = 1'b0; core_active = 1'b0; snap = 1'b0; snap_ack = 1'b0; clr = 1'b0;
    bus.valid = 1'b0; bus.ready = 1'b0; bus.insn = '0;
    test_reset();
    test_basic();
    test_snap_coincident();
    test_handshake();
    test_hold_snap();
    test_clr();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
